// File: rtl/sbox_share_sched.sv
// sbox_share_sched: four shared AES S-boxes time-multiplexed between a SubBytes and a SubWord requester.
module sbox_byte (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'd0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  // GF(2^8) inverse as a^254, followed by the AES affine map
  always_comb begin
    logic [7:0] s, r;
    s = a_i;
    r = 8'd1;
    for (int k = 1; k < 8; k++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    s_o = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  end
endmodule

module sbox_share_sched #(
  parameter bit KEY_PRIORITY = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         st_req,
  input  logic [127:0] st_din,
  output logic         st_gnt,
  output logic         st_done,
  output logic [127:0] st_dout,
  input  logic         kw_req,
  input  logic [31:0]  kw_din,
  output logic         kw_gnt,
  output logic         kw_done,
  output logic [31:0]  kw_dout,
  output logic         busy
);
  localparam logic [1:0] IDLE = 2'd0, ST_RUN = 2'd1, KW_RUN = 2'd2;
  logic [1:0] state_q, state_d, cnt_q, cnt_d;
  logic [127:0] buf_q, buf_d, st_dout_q, st_dout_d;
  logic [31:0] kw_dout_q, kw_dout_d, sb_in, sb_out;
  logic hv_q, hv_d, lk_q, lk_d, st_done_q, kw_done_q, idle, key_win;
  logic [6:0] off;
  assign idle = state_q == IDLE;
  // with no grant history yet, contention falls back to the parameter
  assign key_win = hv_q ? ~lk_q : KEY_PRIORITY;
  assign kw_gnt = rst_n & idle & kw_req & (~st_req | key_win);
  assign st_gnt = rst_n & idle & st_req & ~kw_gnt;
  assign off = {~cnt_q, 5'd0};
  assign sb_in = state_q == KW_RUN ? buf_q[31:0] : buf_q[off +: 32];
  for (genvar g = 0; g < 4; g++) begin : g_sb
    sbox_byte u_sb (.a_i(sb_in[8*g +: 8]), .s_o(sb_out[8*g +: 8]));
  end
  always_comb begin
    state_d = st_gnt ? ST_RUN : kw_gnt ? KW_RUN : (state_q == ST_RUN && cnt_q != 2'd3) ? ST_RUN : IDLE;
    cnt_d = state_q == ST_RUN ? cnt_q + 2'd1 : 2'd0;
    buf_d = st_gnt ? st_din : kw_gnt ? {96'd0, kw_din} : buf_q;
    hv_d = hv_q | st_gnt | kw_gnt;
    lk_d = (st_gnt | kw_gnt) ? kw_gnt : lk_q;
    kw_dout_d = state_q == KW_RUN ? sb_out : kw_dout_q;
    st_dout_d = st_dout_q;
    if (state_q == ST_RUN) st_dout_d[off +: 32] = sb_out;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= 2'd0;
      buf_q <= 128'd0;
      st_dout_q <= 128'd0;
      kw_dout_q <= 32'd0;
      hv_q <= 1'b0;
      lk_q <= 1'b0;
      st_done_q <= 1'b0;
      kw_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      buf_q <= buf_d;
      st_dout_q <= st_dout_d;
      kw_dout_q <= kw_dout_d;
      hv_q <= hv_d;
      lk_q <= lk_d;
      st_done_q <= state_q == ST_RUN && cnt_q == 2'd3;
      kw_done_q <= state_q == KW_RUN;
    end
  end
  assign st_done = st_done_q;
  assign kw_done = kw_done_q;
  assign st_dout = st_dout_q;
  assign kw_dout = kw_dout_q;
  assign busy = ~idle;
endmodule

// File: tb/tb_sbox_share_sched.sv
// tb_sbox_share_sched: scoreboard bench with a log/exp-table S-box model and randomized requesters.
module tb_sbox_share_sched;
  logic clk = 1'b0, rst_n = 1'b0, st_req = 1'b0, kw_req = 1'b0;
  logic [127:0] st_din = 128'd0, st_dout;
  logic [31:0] kw_din = 32'd0, kw_dout;
  logic st_gnt, st_done, kw_gnt, kw_done, busy;
  int checks = 0, errors = 0, cyc = 0, last_sg = 0, last_kg = 0;
  typedef struct { logic [127:0] d; int c; } ent_t;
  ent_t sq[$], kq[$];
  bit ord[$];
  logic [7:0] ex[256], lg[256];
  bit pst = 0, pkw = 0;

  sbox_share_sched #(.KEY_PRIORITY(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .st_req(st_req), .st_din(st_din), .st_gnt(st_gnt),
    .st_done(st_done), .st_dout(st_dout), .kw_req(kw_req), .kw_din(kw_din),
    .kw_gnt(kw_gnt), .kw_done(kw_done), .kw_dout(kw_dout), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string n, input bit ok, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", n, a, e);
    end
  endtask

  function automatic void build_tables();
    logic [7:0] x;
    x = 8'd1;
    for (int i = 0; i < 255; i++) begin
      ex[i] = x;
      lg[x] = 8'(i);
      x = x ^ ({x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00));
    end
  endfunction

  function automatic logic [7:0] sb(input logic [7:0] a);
    logic [7:0] inv, b, c;
    c = 8'h63;
    inv = (a == 8'd0) ? 8'd0 : ex[(255 - int'(lg[a])) % 255];
    for (int i = 0; i < 8; i++)
      b[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
    return b;
  endfunction

  function automatic logic [127:0] sub128(input logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sb(d[8*i +: 8]);
    return r;
  endfunction

  function automatic logic [31:0] sub32(input logic [31:0] d);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sb(d[8*i +: 8]);
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic req_st(input logic [127:0] d, input bit keep);
    int n;
    ent_t e;
    st_din = d;
    st_req = 1'b1;
    n = 0;
    @(negedge clk);
    while (!st_gnt && n < 300) begin @(negedge clk); n++; end
    if (!st_gnt) begin
      chk("st_gnt_timeout", 1'b0, 128'(n), 128'd0);
      st_req = 1'b0;
      return;
    end
    e.d = sub128(d);
    e.c = cyc;
    sq.push_back(e);
    last_sg = cyc;
    ord.push_back(1'b0);
    @(posedge clk); #1;
    st_req = keep;
    st_din = rnd128();
  endtask

  task automatic req_kw(input logic [31:0] d, input bit keep);
    int n;
    ent_t e;
    kw_din = d;
    kw_req = 1'b1;
    n = 0;
    @(negedge clk);
    while (!kw_gnt && n < 300) begin @(negedge clk); n++; end
    if (!kw_gnt) begin
      chk("kw_gnt_timeout", 1'b0, 128'(n), 128'd0);
      kw_req = 1'b0;
      return;
    end
    e.d = {96'd0, sub32(d)};
    e.c = cyc;
    kq.push_back(e);
    last_kg = cyc;
    ord.push_back(1'b1);
    @(posedge clk); #1;
    kw_req = keep;
    kw_din = $urandom;
  endtask

  always @(negedge clk) begin
    ent_t e;
    if (rst_n) begin
      if (st_done) begin
        if (sq.size() == 0) chk("st_done_unexpected", 1'b0, 128'd1, 128'd0);
        else begin
          e = sq.pop_front();
          chk("st_dout", st_dout == e.d, st_dout, e.d);
          chk("st_latency", cyc - e.c == 5, 128'(cyc - e.c), 128'd5);
        end
      end
      if (kw_done) begin
        if (kq.size() == 0) chk("kw_done_unexpected", 1'b0, 128'd1, 128'd0);
        else begin
          e = kq.pop_front();
          chk("kw_dout", {96'd0, kw_dout} == e.d, {96'd0, kw_dout}, e.d);
          chk("kw_latency", cyc - e.c == 2, 128'(cyc - e.c), 128'd2);
        end
      end
      if (st_done || kw_done) begin
        chk("done_exclusive", !(st_done && kw_done), {st_done, kw_done}, 128'd0);
        chk("done_one_cycle", !(st_done && pst) && !(kw_done && pkw), {pst, st_done, pkw, kw_done}, 128'd0);
      end
      if (st_gnt || kw_gnt)
        chk("gnt_only_idle_single", !(st_gnt && kw_gnt) && !busy, {st_gnt, kw_gnt, busy}, 128'd0);
    end
    pst = st_done;
    pkw = kw_done;
  end

  initial begin
    int n;
    logic [127:0] d;
    build_tables();
    st_req = 1'b1;
    kw_req = 1'b1;
    st_din = rnd128();
    kw_din = $urandom;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", {st_gnt, kw_gnt, st_done, kw_done, busy} == 5'd0, {st_gnt, kw_gnt, st_done, kw_done, busy}, 128'd0);
    chk("reset_st_dout", st_dout == 128'd0, st_dout, 128'd0);
    chk("reset_kw_dout", kw_dout == 32'd0, {96'd0, kw_dout}, 128'd0);
    rst_n = 1'b1;
    ord.delete();
    fork
      begin
        repeat (9) req_kw($urandom, 1'b1);
        req_kw($urandom, 1'b0);
      end
      begin
        repeat (9) req_st(rnd128(), 1'b1);
        req_st(rnd128(), 1'b0);
      end
    join
    chk("contention_count", ord.size() == 20, 128'(ord.size()), 128'd20);
    for (int i = 0; i < ord.size(); i++)
      chk("contention_alternate", ord[i] == (i % 2 == 0), 128'(ord[i]), 128'(i % 2 == 0));
    repeat (8) @(posedge clk);
    #1;
    req_st(128'h00112233445566778899aabbccddeeff, 1'b0);
    repeat (4) begin
      @(negedge clk);
      chk("st_busy", busy == 1'b1, 128'(busy), 128'd1);
    end
    @(negedge clk);
    chk("st_done_T5", st_done && !busy, {st_done, busy}, 128'd2);
    chk("st_known_answer", st_dout == 128'h638293c31bfc33f5c4eeacea4bc12816, st_dout, 128'h638293c31bfc33f5c4eeacea4bc12816);
    @(posedge clk); #1;
    req_kw(32'h09cf4f3c, 1'b0);
    @(negedge clk);
    chk("kw_busy", busy == 1'b1, 128'(busy), 128'd1);
    @(negedge clk);
    chk("kw_done_T2", kw_done && !busy, {kw_done, busy}, 128'd2);
    chk("kw_known_answer", kw_dout == 32'h018a84eb, {96'd0, kw_dout}, 128'h018a84eb);
    @(posedge clk); #1;
    req_st(rnd128(), 1'b0);
    @(posedge clk); #1;
    req_kw(32'h09cf4f3c, 1'b0);
    chk("kw_gnt_at_st_done", last_kg - last_sg == 5, 128'(last_kg - last_sg), 128'd5);
    repeat (4) @(posedge clk);
    #1;
    d = rnd128();
    req_st(d, 1'b0);
    @(posedge clk); #1;
    st_req = 1'b1;
    kw_req = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("midreset_ctrl", {st_gnt, kw_gnt, st_done, kw_done, busy} == 5'd0, {st_gnt, kw_gnt, st_done, kw_done, busy}, 128'd0);
    chk("midreset_douts", st_dout == 128'd0 && kw_dout == 32'd0, st_dout ^ {96'd0, kw_dout}, 128'd0);
    sq.delete();
    @(posedge clk); #1;
    st_req = 1'b0;
    kw_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("no_done_after_abort", sq.size() == 0 && st_dout == 128'd0, st_dout, 128'd0);
    req_st(d, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    fork
      repeat (25) begin
        repeat ($urandom_range(0, 5)) @(posedge clk);
        #1;
        req_st(rnd128(), 1'b0);
      end
      repeat (25) begin
        repeat ($urandom_range(0, 5)) @(posedge clk);
        #1;
        req_kw($urandom, 1'b0);
      end
    join
    n = 0;
    while ((sq.size() != 0 || kq.size() != 0) && n < 100) begin @(posedge clk); n++; end
    @(negedge clk);
    chk("drain", sq.size() == 0 && kq.size() == 0, 128'(sq.size() + kq.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sbox_share_sched.md
SBOX_SHARE_SCHED -- requirements
Module: sbox_share_sched

Interface
REQ-001 The block SHALL have one parameter: KEY_PRIORITY, default 1, which is the winner of the first contention after reset (1 = key requester, 0 = state requester).
REQ-002 clk  input  1  the single clock; all state updates SHALL occur on its rising edge.
REQ-003 rst_n  input  1  the reset, which SHALL be asynchronous and active-low.
REQ-004 st_req  input  1  the state requester's SubBytes request, level-sensitive.
REQ-005 st_din  input  128  the state operand; byte 15 is bits 127:120.
REQ-006 st_gnt  output  1  the state request accept; combinational and asserted only in IDLE.
REQ-007 st_done  output  1  a one-cycle pulse that SHALL mark st_dout as valid.
REQ-008 st_dout  output  128  the SubBytes result.
REQ-009 kw_req  input  1  the key-expansion SubWord request, level-sensitive.
REQ-010 kw_din  input  32  the key word operand.
REQ-011 kw_gnt  output  1  the key request accept; combinational and asserted only in IDLE.
REQ-012 kw_done  output  1  a one-cycle pulse that SHALL mark kw_dout as valid.
REQ-013 kw_dout  output  32  the SubWord result.
REQ-014 busy  output  1  SHALL be high whenever the state machine is not in IDLE.

Function
REQ-015 The block SHALL instantiate exactly four byte S-box lookup instances and SHALL share them between the two requesters; no other substitution logic is permitted.
REQ-016 The state machine SHALL have the states IDLE, ST_RUN and KW_RUN.
REQ-017 In IDLE, at most one grant SHALL be asserted per cycle.
REQ-018 In IDLE with a single requester, that requester SHALL be granted.
REQ-019 In IDLE with both requesters, the winner SHALL be the requester not granted most recently; the first contention after reset SHALL go to the requester selected by KEY_PRIORITY.
REQ-020 On the grant edge, the block SHALL capture the operand into an internal buffer; the requester may change din after that edge.
REQ-021 After a state grant at cycle T, ST_RUN SHALL occupy cycles T+1..T+4 with word counter 0..3.
REQ-022 In ST_RUN, word 0 = bits 127:96 and word 3 = bits 31:0; each cycle the four S-boxes SHALL process the buffered word[cnt], and the result SHALL be written to st_dout word[cnt] at that edge.
REQ-023 After a state grant, the block SHALL return to IDLE after T+4 and SHALL pulse st_done in cycle T+5; latency from grant is 5 cycles.
REQ-024 After a key grant at cycle T, KW_RUN SHALL occupy cycle T+1, and kw_dout SHALL be updated at that edge.
REQ-025 After a key grant, the block SHALL return to IDLE and SHALL pulse kw_done in cycle T+2; latency from grant is 2 cycles.
REQ-026 A new grant SHALL be possible in the same cycle as a done pulse, because the state machine is in IDLE during that cycle.
REQ-027 While ST_RUN or KW_RUN is active, requests SHALL be ignored and not queued; requesters SHALL hold req until granted.
REQ-028 A req still held in the cycle after its own grant SHALL be treated as a new request.
REQ-029 st_dout SHALL hold its last complete result, except during ST_RUN when it is partially updated; it is valid only on st_done. kw_dout SHALL hold until the next KW_RUN.
REQ-030 The done pulses SHALL never be asserted for more than one cycle.
REQ-031 st_done and kw_done SHALL never be asserted in the same cycle.

Reset
REQ-032 When rst_n is low, the block SHALL asynchronously go to IDLE, clear the counter and buffer, and set st_dout and kw_dout to 0.
REQ-033 When rst_n is low, st_done, kw_done, busy, st_gnt and kw_gnt SHALL be 0, and the last-grant history SHALL be cleared.
REQ-034 A reset during ST_RUN or KW_RUN SHALL abort the operation with no done pulse; the requester SHALL re-request after reset.
REQ-035 Reset SHALL be released synchronously to clk by the integrator.

Verification
REQ-036 State op: st_din=00112233445566778899aabbccddeeff, single request -> st_gnt at T, busy T+1..T+4, st_done at T+5, st_dout=638293c31bfc33f5c4eeacea4bc12816.
REQ-037 Key op: kw_din=09cf4f3c -> kw_gnt at T, kw_done at T+2, kw_dout=018a84eb.
REQ-038 Contention: KEY_PRIORITY=1, both req asserted from reset release -> key granted first, state granted at the kw_done cycle, then alternation continues while both stay asserted; no starvation over 20 operations.
REQ-039 Request during busy: kw_req asserted at T+2 of a state op -> no kw_gnt before T+5; kw_gnt at T+5 coincides with st_done.
REQ-040 Reset mid-op: rst_n low at T+2 of a state op -> all outputs 0 immediately; no st_done; after release, the re-requested op completes with the correct result.
REQ-041 Operand change after grant: st_din changed at T+1 -> result still reflects the value captured at T.
